// File: rtl/page_mgr_pkg.sv
// Shared types and helpers for the page-manager responder.
package page_mgr_pkg;

  localparam logic PM_OK   = 1'b1;
  localparam logic PM_FAIL = 1'b0;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } pm_state_e;

  // Reply word: status in bit rep_w-1, block index in the low block_w bits, zeros elsewhere.
  // Callers truncate the 32-bit result to their reply width.
  function automatic logic [31:0] pack_reply(input logic        status,
                                             input logic [31:0] index,
                                             input int unsigned rep_w,
                                             input int unsigned block_w);
    logic [31:0] mask;
    mask = (32'd1 << block_w) - 32'd1;
    return (index & mask) | (32'(status) << (rep_w - 1));
  endfunction

endpackage

// File: rtl/free_list_fifo.sv
// Circular free list of block indices with simultaneous push/pop and an init write port.
module free_list_fifo
  import page_mgr_pkg::*;
#(
  parameter int unsigned BLOCK_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_we,
  input  logic [BLOCK_W-1:0] init_addr,
  input  logic               init_load,
  input  logic               push,
  input  logic [BLOCK_W-1:0] push_data,
  input  logic               pop,
  output logic [BLOCK_W-1:0] pop_data,
  output logic [BLOCK_W:0]   count
);

  localparam int unsigned NUM_BLOCKS = 2 ** BLOCK_W;
  localparam int unsigned CNT_W      = BLOCK_W + 1;

  logic [BLOCK_W-1:0] ram [NUM_BLOCKS];
  logic [BLOCK_W-1:0] head;
  logic [BLOCK_W-1:0] tail;

  always_ff @(posedge clk) begin
    if (init_we) begin
      ram[init_addr] <= init_addr;
    end else if (push) begin
      ram[tail] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (init_load) begin
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(NUM_BLOCKS);
    end else begin
      head  <= head + BLOCK_W'(pop);
      tail  <= tail + BLOCK_W'(push);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign pop_data = ram[head];

endmodule

// File: rtl/page_manager_responder.sv
// Manager-side endpoint of the page-manager channel: free list, allocation bitmap, reply registers.
module page_manager_responder
  import page_mgr_pkg::*;
#(
  parameter int unsigned REQ_W   = 8,
  parameter int unsigned REP_W   = 9,
  parameter int unsigned BLOCK_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               s_req_alloc_vld,
  output logic               s_req_alloc_rdy,
  input  logic [REQ_W-1:0]   s_req_alloc_data,
  input  logic               s_req_dealloc_vld,
  output logic               s_req_dealloc_rdy,
  input  logic [REP_W-1:0]   s_req_dealloc_data,
  output logic               m_rep_alloc_vld,
  input  logic               m_rep_alloc_rdy,
  output logic [REP_W-1:0]   m_rep_alloc_data,
  output logic               m_rep_dealloc_vld,
  input  logic               m_rep_dealloc_rdy,
  output logic [REP_W-1:0]   m_rep_dealloc_data,
  output logic [BLOCK_W:0]   o_free_cnt,
  output logic               o_init_done
);

  localparam int unsigned NUM_BLOCKS = 2 ** BLOCK_W;

  pm_state_e              state;
  pm_state_e              state_nxt;
  logic [BLOCK_W-1:0]     init_idx;
  logic                   init_we;
  logic                   init_load;
  logic                   run;
  logic [NUM_BLOCKS-1:0]  bitmap;

  logic                   alloc_fire;
  logic                   alloc_ok;
  logic [BLOCK_W-1:0]     pop_idx;
  logic                   dealloc_fire;
  logic                   dealloc_ok;
  logic [BLOCK_W-1:0]     dealloc_idx;
  logic                   unused_bits;

  assign unused_bits = ^{s_req_alloc_data, s_req_dealloc_data[REP_W-1:BLOCK_W]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    init_we   = 1'b0;
    init_load = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_idx == '1) begin
          init_load = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      init_idx <= '0;
    end else if (init_we) begin
      init_idx <= init_idx + BLOCK_W'(1);
    end
  end

  assign run         = (state == ST_RUN);
  assign o_init_done = run;

  assign s_req_alloc_rdy   = run && (!m_rep_alloc_vld || m_rep_alloc_rdy);
  assign s_req_dealloc_rdy = run && (!m_rep_dealloc_vld || m_rep_dealloc_rdy);

  // Both channel decisions look only at pre-cycle count and bitmap.
  assign alloc_fire   = s_req_alloc_vld && s_req_alloc_rdy;
  assign alloc_ok     = alloc_fire && (o_free_cnt != '0);
  assign dealloc_idx  = s_req_dealloc_data[BLOCK_W-1:0];
  assign dealloc_fire = s_req_dealloc_vld && s_req_dealloc_rdy;
  assign dealloc_ok   = dealloc_fire && bitmap[dealloc_idx];

  free_list_fifo #(
    .BLOCK_W (BLOCK_W)
  ) u_free_list (
    .clk       (i_clk),
    .rst       (i_rst),
    .init_we   (init_we),
    .init_addr (init_idx),
    .init_load (init_load),
    .push      (dealloc_ok),
    .push_data (dealloc_idx),
    .pop       (alloc_ok),
    .pop_data  (pop_idx),
    .count     (o_free_cnt)
  );

  // A popped index is free and a pushed index is allocated, so the two bit updates never collide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bitmap <= '0;
    end else begin
      if (alloc_ok) begin
        bitmap[pop_idx] <= 1'b1;
      end
      if (dealloc_ok) begin
        bitmap[dealloc_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_rep_alloc_vld  <= 1'b0;
      m_rep_alloc_data <= '0;
    end else if (alloc_fire) begin
      m_rep_alloc_vld  <= 1'b1;
      m_rep_alloc_data <= REP_W'(pack_reply(alloc_ok ? PM_OK : PM_FAIL,
                                            alloc_ok ? 32'(pop_idx) : 32'd0,
                                            REP_W, BLOCK_W));
    end else if (m_rep_alloc_rdy) begin
      m_rep_alloc_vld <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_rep_dealloc_vld  <= 1'b0;
      m_rep_dealloc_data <= '0;
    end else if (dealloc_fire) begin
      m_rep_dealloc_vld  <= 1'b1;
      m_rep_dealloc_data <= REP_W'(pack_reply(dealloc_ok ? PM_OK : PM_FAIL,
                                              32'(dealloc_idx), REP_W, BLOCK_W));
    end else if (m_rep_dealloc_rdy) begin
      m_rep_dealloc_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_page_manager_responder.sv
module tb_page_manager_responder;

  localparam int unsigned BW = 4;
  localparam int unsigned RW = 9;
  localparam int unsigned QW = 8;
  localparam int unsigned NB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_vld, a_rdy;
  logic [QW-1:0] a_data;
  logic          d_vld, d_rdy;
  logic [RW-1:0] d_data;
  logic          ra_vld, ra_rdy;
  logic [RW-1:0] ra_data;
  logic          rd_vld, rd_rdy;
  logic [RW-1:0] rd_data;
  logic [BW:0]   free_cnt;
  logic          init_done;

  int errors = 0;
  int checks = 0;

  // Behavioural model: free list as a queue, allocation flags, one pending reply per channel.
  int       q_free[$];
  bit       bm[NB];
  bit       run_m;
  bit       ea_vld, ed_vld;
  logic [RW-1:0] ea_data, ed_data;

  always #5 clk = ~clk;

  page_manager_responder #(
    .REQ_W   (QW),
    .REP_W   (RW),
    .BLOCK_W (BW)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .s_req_alloc_vld    (a_vld),
    .s_req_alloc_rdy    (a_rdy),
    .s_req_alloc_data   (a_data),
    .s_req_dealloc_vld  (d_vld),
    .s_req_dealloc_rdy  (d_rdy),
    .s_req_dealloc_data (d_data),
    .m_rep_alloc_vld    (ra_vld),
    .m_rep_alloc_rdy    (ra_rdy),
    .m_rep_alloc_data   (ra_data),
    .m_rep_dealloc_vld  (rd_vld),
    .m_rep_dealloc_rdy  (rd_rdy),
    .m_rep_dealloc_data (rd_data),
    .o_free_cnt         (free_cnt),
    .o_init_done        (init_done)
  );

  function automatic logic [RW-1:0] rep(bit ok, int idx);
    logic [3:0] i4;
    i4 = idx[3:0];
    return {ok, 4'b0000, i4};
  endfunction

  task automatic model_reset();
    q_free.delete();
    foreach (bm[i]) bm[i] = 1'b0;
    ea_vld = 1'b0;
    ed_vld = 1'b0;
    run_m  = 1'b0;
  endtask

  task automatic model_init_done();
    for (int unsigned i = 0; i < NB; i++) q_free.push_back(int'(i));
    run_m = 1'b1;
  endtask

  // Applies one clock edge worth of requests, using the inputs currently driven.
  task automatic model_step();
    bit a_acc, d_acc, a_ok, d_ok;
    int a_idx, b;
    a_acc = a_vld && run_m && (!ea_vld || ra_rdy);
    d_acc = d_vld && run_m && (!ed_vld || rd_rdy);
    b     = int'(d_data[3:0]);
    a_ok  = a_acc && (q_free.size() > 0);
    a_idx = a_ok ? q_free[0] : 0;
    d_ok  = d_acc && bm[b];
    if (a_ok) begin
      void'(q_free.pop_front());
      bm[a_idx] = 1'b1;
    end
    if (d_ok) begin
      bm[b] = 1'b0;
      q_free.push_back(b);
    end
    if (a_acc) begin
      ea_vld  = 1'b1;
      ea_data = rep(a_ok, a_idx);
    end else if (ra_rdy) begin
      ea_vld = 1'b0;
    end
    if (d_acc) begin
      ed_vld  = 1'b1;
      ed_data = rep(d_ok, b);
    end else if (rd_rdy) begin
      ed_vld = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_vld = 0; d_vld = 0; a_data = '0; d_data = '0; ra_rdy = 1; rd_rdy = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_rdy, d_rdy, ra_vld, rd_vld, init_done} !== 5'b0 || ra_data !== '0 ||
        rd_data !== '0 || free_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b%b vld=%b%b done=%b ad=%h dd=%h cnt=%0d, expected all zero",
               a_rdy, d_rdy, ra_vld, rd_vld, init_done, ra_data, rd_data, free_cnt);
    end
    rst   = 1'b0;
    a_vld = 1'b1;
    d_vld = 1'b1;
    for (int unsigned k = 1; k <= NB; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (init_done !== (k == NB) || free_cnt !== ((k == NB) ? 5'd16 : 5'd0) ||
          a_rdy !== (k == NB) || d_rdy !== (k == NB) || ra_vld !== 1'b0 || rd_vld !== 1'b0) begin
        errors++;
        $display("FAIL init_cycle_%0d: got done=%b cnt=%0d rdy=%b%b vld=%b%b, expected done=%b cnt=%0d rdy=%b%b vld=00",
                 k, init_done, free_cnt, a_rdy, d_rdy, ra_vld, rd_vld, (k == NB),
                 (k == NB) ? 16 : 0, (k == NB), (k == NB));
      end
    end
    a_vld = 1'b0;
    d_vld = 1'b0;
    model_init_done();
  endtask

  task automatic test_alloc_drain();
    logic [RW-1:0] lit;
    a_vld = 1'b1;
    for (int unsigned i = 0; i <= NB; i++) begin
      tick();
      lit = (i < NB) ? rep(1'b1, int'(i)) : rep(1'b0, 0);
      checks++;
      if (ra_vld !== 1'b1 || ra_data !== lit || ra_data !== ea_data) begin
        errors++;
        $display("FAIL alloc_drain_%0d: got vld=%b data=%h, expected vld=1 data=%h", i, ra_vld, ra_data, lit);
      end
    end
    a_vld = 1'b0;
    tick();
    checks++;
    if (free_cnt !== 5'd0 || ra_vld !== 1'b0) begin
      errors++;
      $display("FAIL alloc_drain_end: got cnt=%0d vld=%b, expected cnt=0 vld=0", free_cnt, ra_vld);
    end
  endtask

  task automatic test_double_free();
    d_vld  = 1'b1;
    d_data = 9'h003;
    tick();
    checks++;
    if (rd_vld !== 1'b1 || rd_data !== 9'h103 || free_cnt !== 5'd1) begin
      errors++;
      $display("FAIL free_3: got vld=%b data=%h cnt=%0d, expected vld=1 data=103 cnt=1", rd_vld, rd_data, free_cnt);
    end
    tick();
    checks++;
    if (rd_vld !== 1'b1 || rd_data !== 9'h003 || free_cnt !== 5'd1) begin
      errors++;
      $display("FAIL double_free_3: got vld=%b data=%h cnt=%0d, expected vld=1 data=003 cnt=1", rd_vld, rd_data, free_cnt);
    end
    d_vld = 1'b0;
    a_vld = 1'b1;
    tick();
    checks++;
    if (ra_vld !== 1'b1 || ra_data !== 9'h103 || free_cnt !== 5'd0 || ra_data !== ea_data) begin
      errors++;
      $display("FAIL realloc_after_wrap: got vld=%b data=%h cnt=%0d, expected vld=1 data=103 cnt=0", ra_vld, ra_data, free_cnt);
    end
    a_vld = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    a_vld  = 1'b1;
    d_vld  = 1'b1;
    d_data = 9'h005;
    tick();
    checks++;
    if (ra_data !== 9'h000 || rd_data !== 9'h105 || ra_vld !== 1'b1 || rd_vld !== 1'b1 || free_cnt !== 5'd1) begin
      errors++;
      $display("FAIL same_cycle: got alloc=%b/%h dealloc=%b/%h cnt=%0d, expected alloc=1/000 dealloc=1/105 cnt=1",
               ra_vld, ra_data, rd_vld, rd_data, free_cnt);
    end
    a_vld = 1'b0;
    d_vld = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    ra_rdy = 1'b0;
    a_vld  = 1'b1;
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (a_rdy !== 1'b0 || ra_vld !== 1'b1 || ra_data !== 9'h105 || free_cnt !== 5'd0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got rdy=%b vld=%b data=%h cnt=%0d, expected rdy=0 vld=1 data=105 cnt=0",
                 i, a_rdy, ra_vld, ra_data, free_cnt);
      end
      tick();
    end
    ra_rdy = 1'b1;
    #1;
    checks++;
    if (a_rdy !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release_rdy: got %b, expected 1", a_rdy);
    end
    tick();
    checks++;
    if (ra_vld !== 1'b1 || ra_data !== 9'h000) begin
      errors++;
      $display("FAIL backpressure_resume: got vld=%b data=%h, expected vld=1 data=000", ra_vld, ra_data);
    end
    a_vld = 1'b0;
    tick();
    checks++;
    if (ra_vld !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: got vld=%b, expected 0", ra_vld);
    end
  endtask

  task automatic test_random(input int unsigned cycles);
    int alloc_list[$];
    int idx;
    for (int unsigned c = 0; c < cycles; c++) begin
      alloc_list.delete();
      foreach (bm[i]) if (bm[i]) alloc_list.push_back(i);
      a_vld  = ($urandom_range(0, 1) == 1);
      d_vld  = ($urandom_range(0, 1) == 1);
      a_data = QW'($urandom);
      idx    = (alloc_list.size() > 0 && $urandom_range(0, 3) != 0) ?
               alloc_list[$urandom_range(0, alloc_list.size() - 1)] : int'($urandom_range(0, NB - 1));
      d_data = {5'($urandom), 4'(idx)};
      ra_rdy = ($urandom_range(0, 9) < 7);
      rd_rdy = ($urandom_range(0, 9) < 7);
      #1;
      checks++;
      if (a_rdy !== (run_m && (!ea_vld || ra_rdy)) || d_rdy !== (run_m && (!ed_vld || rd_rdy))) begin
        errors++;
        $display("FAIL random_rdy_%0d: got a=%b d=%b, expected a=%b d=%b", c, a_rdy, d_rdy,
                 run_m && (!ea_vld || ra_rdy), run_m && (!ed_vld || rd_rdy));
      end
      tick();
      checks++;
      if (ra_vld !== ea_vld || rd_vld !== ed_vld || (ea_vld && ra_data !== ea_data) ||
          (ed_vld && rd_data !== ed_data) || free_cnt !== 5'(q_free.size())) begin
        errors++;
        $display("FAIL random_out_%0d: got a=%b/%h d=%b/%h cnt=%0d, expected a=%b/%h d=%b/%h cnt=%0d", c,
                 ra_vld, ra_data, rd_vld, rd_data, free_cnt, ea_vld, ea_data, ed_vld, ed_data, q_free.size());
      end
    end
    a_vld = 1'b0;
    d_vld = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_vld = 0; d_vld = 0; ra_rdy = 1; rd_rdy = 1;
    tick();
    ra_rdy = 0; rd_rdy = 0; a_vld = 1; d_vld = 1; d_data = 9'h000;
    tick();
    checks++;
    if (ra_vld !== 1'b1 || rd_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pending: got vld=%b%b, expected 11", ra_vld, rd_vld);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_rdy, d_rdy, ra_vld, rd_vld, init_done} !== 5'b0 || ra_data !== '0 ||
        rd_data !== '0 || free_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got rdy=%b%b vld=%b%b done=%b ad=%h dd=%h cnt=%0d, expected all zero",
               a_rdy, d_rdy, ra_vld, rd_vld, init_done, ra_data, rd_data, free_cnt);
    end
    a_vld = 0; d_vld = 0; ra_rdy = 1; rd_rdy = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int unsigned k = 1; k <= NB; k++) begin
      @(posedge clk);
      #1;
      if (k >= NB - 1) begin
        checks++;
        if (init_done !== (k == NB) || free_cnt !== ((k == NB) ? 5'd16 : 5'd0)) begin
          errors++;
          $display("FAIL reset_mid_init_%0d: got done=%b cnt=%0d, expected done=%b cnt=%0d",
                   k, init_done, free_cnt, (k == NB), (k == NB) ? 16 : 0);
        end
      end
    end
    model_init_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc_drain();
    test_double_free();
    test_same_cycle();
    test_backpressure();
    test_random(400);
    test_reset_mid();
    test_random(150);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
